// File: rtl/fetch_unit.sv
// Instruction fetch: pc register feeding a 2-entry {instr, pc} buffer toward decode.
// Latency: a word fetched in cycle N is visible on out_* in cycle N+1 when the buffer is empty.
// Backpressure: fetch stalls (pc holds) while the buffer is full and decode does not accept the head.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [11:0] im_addr,
    input  logic [31:0] im_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    // Buffer entry pairing a fetched word with the byte address it came from.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    logic [31:0] pc;
    logic [1:0]  count;
    entry_t      head;
    entry_t      tail;
    logic        pop;
    logic        push;
    logic [1:0]  wr_idx;
    entry_t      fetched;

    // Handshake decode: a redirect suppresses fetch; a full buffer fetches only when the head leaves.
    always_comb begin
        pop     = out_valid && out_ready;
        push    = !redirect_valid && ((count < 2'd2) || pop);
        wr_idx  = count - {1'b0, pop};
        fetched = '{instr: im_instr, pc: pc};
    end

    // Memory sees only the word index within the 16 KB window.
    assign im_addr   = pc[13:2];
    assign out_valid = (count != 2'd0);
    assign out_instr = out_valid ? head.instr : 32'h0;
    assign out_pc    = out_valid ? head.pc    : 32'h0;

    // pc, occupancy and entry storage; reset beats redirect, redirect beats push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= RESET_PC;
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else if (redirect_valid) begin
            // Flush: old entries become unreachable once count is zero.
            pc    <= {redirect_pc[31:2], 2'b00};
            count <= 2'd0;
        end else begin
            if (pop) begin
                head <= tail;
            end
            // Write after the shift so a push into slot 0 wins over the shifted-in value.
            if (push) begin
                if (wr_idx == 2'd0) begin
                    head <= fetched;
                end else begin
                    tail <= fetched;
                end
                pc <= pc + 32'd4;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, stall, redirect, reset-over-redirect, wrap.
// Instruction memory model returns 32'h1000_0000 + word index, combinationally.
// Outputs are sampled 1 time unit after each rising edge, inputs changed at the same point.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [11:0] im_addr;
    logic [31:0] im_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int errors = 0;
    int checks = 0;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .im_addr        (im_addr),
        .im_instr       (im_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    assign im_instr = 32'h1000_0000 + {20'h0, im_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks a valid head with the instruction the memory model holds for that pc.
    task automatic chk_head(input string tag, input logic [31:0] exp_pc);
        chk({tag, "_vld"}, {31'h0, out_valid}, 32'd1);
        chk({tag, "_pc"}, out_pc, exp_pc);
        chk({tag, "_instr"}, out_instr, 32'h1000_0000 + {20'h0, exp_pc[13:2]});
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_vld"}, {31'h0, out_valid}, 32'd0);
        chk({tag, "_pc"}, out_pc, 32'h0);
        chk({tag, "_instr"}, out_instr, 32'h0);
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        tick();
        tick();

        // Reset state and first fetch address.
        chk_empty("rst");
        chk("rst_imaddr", {20'h0, im_addr}, 32'h0000_0C00);
        reset     = 1'b0;
        out_ready = 1'b1;

        // Streaming with decode always ready: one instruction per cycle.
        tick(); chk_head("s0", 32'h0000_3000);
        tick(); chk_head("s1", 32'h0000_3004);
        tick(); chk_head("s2", 32'h0000_3008);

        // Fresh reset, then decode stalls for five cycles.
        reset = 1'b1;
        tick(); chk_empty("rst2");
        reset     = 1'b0;
        out_ready = 1'b0;
        repeat (5) tick();
        chk_head("stall", 32'h0000_3000);
        chk("stall_imaddr", {20'h0, im_addr}, 32'h0000_0C02);
        out_ready = 1'b1;
        tick(); chk_head("res0", 32'h0000_3004);
        tick(); chk_head("res1", 32'h0000_3008);
        tick(); chk_head("res2", 32'h0000_300C);

        // Redirect with buffer full, misaligned target, decode ready (ignored).
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3043;
        tick(); chk_empty("redir_full");
        chk("redir_imaddr", {20'h0, im_addr}, 32'h0000_0C10);
        redirect_valid = 1'b0;
        tick(); chk_head("redir_tgt", 32'h0000_3040);

        // Redirect with one entry while decode is ready: head is dropped.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3100;
        tick(); chk_empty("redir_one");
        redirect_valid = 1'b0;
        tick(); chk_head("redir_one_tgt", 32'h0000_3100);

        // Back-to-back redirects: the last target wins, nothing fetched in between.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3200;
        tick(); chk_empty("rr0");
        redirect_pc    = 32'h0000_3300;
        tick(); chk_empty("rr1");
        chk("rr_imaddr", {20'h0, im_addr}, 32'h0000_0CC0);
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        tick(); chk_head("rr_tgt", 32'h0000_3300);
        tick(); chk_head("rr_hold", 32'h0000_3300);

        // Reset together with redirect while full: reset wins.
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3400;
        tick(); chk_empty("rst_redir");
        chk("rst_redir_imaddr", {20'h0, im_addr}, 32'h0000_0C00);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        tick(); chk_head("rst_redir_first", 32'h0000_3000);

        // pc wrap-around from the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick(); chk_empty("wrap_redir");
        chk("wrap_imaddr", {20'h0, im_addr}, 32'h0000_0FFF);
        redirect_valid = 1'b0;
        tick(); chk_head("wrap0", 32'hFFFF_FFFC);
        tick(); chk_head("wrap1", 32'h0000_0000);
        tick(); chk_head("wrap2", 32'h0000_0004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, address of the first instruction fetched after reset.
REQ-002 clk  input  1  Single clock; all state updates on the rising edge.
REQ-003 reset  input  1  Reset, synchronous and active-high.
REQ-004 im_addr  output  12  Word address to the instruction memory; equals pc[13:2].
REQ-005 im_instr  input  32  Instruction word returned combinationally by the instruction memory for im_addr in the same cycle.
REQ-006 redirect_valid  input  1  Branch/jump taken; redirect fetch this cycle.
REQ-007 redirect_pc  input  32  Redirect target byte address.
REQ-008 out_valid  output  1  Head of buffer holds a valid instruction.
REQ-009 out_ready  input  1  Decode stage accepts the head this cycle.
REQ-010 out_instr  output  32  Instruction at buffer head.
REQ-011 out_pc  output  32  Byte address of out_instr.

Function
REQ-012 The block SHALL hold a 32-bit pc register and a 2-entry FIFO of {instr[31:0], pc[31:0]} pairs with a count of 0..2.
REQ-013 im_addr SHALL be driven as pc[13:2] combinationally; pc[31:14] and pc[1:0] are not sent to memory.
REQ-014 pop SHALL be defined as out_valid AND out_ready.
REQ-015 push SHALL be defined as NOT redirect_valid AND (count < 2 OR pop); on push, the pair {im_instr, pc} is written to the tail and pc <= pc + 4 (32-bit wrap-around, carry discarded).
REQ-016 When no push occurs and no redirect occurs, pc SHALL hold.
REQ-017 count SHALL update as count + push - pop; simultaneous push and pop at count 2 leaves count at 2 with head advanced.
REQ-018 out_valid SHALL equal (count != 0); out_instr/out_pc SHALL show the head entry when count != 0, and 32'h0 when count == 0.
REQ-019 Latency: an instruction pushed in cycle N SHALL appear at out_* in cycle N+1 if the FIFO was empty.
REQ-020 redirect_valid SHALL have priority over push and pop: FIFO flushed (count <= 0, entries discarded, no pop reported as accepted), pc <= {redirect_pc[31:2], 2'b00}; out_ready in that cycle is ignored.
REQ-021 The first fetch from the redirect target SHALL occur in the cycle after redirect_valid; its output appears one cycle later.
REQ-022 redirect_valid asserted on consecutive cycles SHALL take the last target, with no push in between.
REQ-023 out_ready while out_valid is 0 SHALL have no effect.

Reset
REQ-024 While reset is high on a rising edge: pc <= RESET_PC, count <= 0, all FIFO entries <= 0; reset overrides redirect, push and pop.
REQ-025 In the cycle after reset deasserts, out_valid = 0, out_instr = 0, out_pc = 0, im_addr = RESET_PC[13:2] = 12'hC00, and the first push occurs in that cycle.

Verification
REQ-026 Reset, then out_ready=1 constantly, memory word k = 32'h1000_0000+k -> out_pc sequence 3000,3004,3008 one per cycle from second post-reset cycle with matching instr.
REQ-027 out_ready=0 for 5 cycles after reset -> count saturates at 2, pc stops at 32'h3008, out_pc stays 32'h3000; out_ready=1 then resumes one per cycle without loss or duplication.
REQ-028 Redirect_valid=1, redirect_pc=32'h0000_3043 while count=2 -> next cycle out_valid=0, pc=32'h3040; following cycle out_pc=32'h3040.
REQ-029 Redirect_valid and out_ready both high with count=1 -> head dropped, not counted as delivered; next valid out_pc is the target.
REQ-030 Reset asserted mid-stream with count=2 and redirect_valid=1 -> pc=RESET_PC, out_valid=0 next cycle; redirect ignored.
REQ-031 pc loaded 32'hFFFF_FFFC via redirect, out_ready=1 -> out_pc FFFFFFFC followed by 00000000 (wrap).
